// File: rtl/minimig_sram_sequencer_if.sv
// Bridge-side request/response and external SRAM pin bundle for minimig_sram_sequencer.
// The sequencer takes the slave view; the bridge/pad side takes the master view.
interface minimig_sram_sequencer_if;
    logic        _req_we;
    logic        _req_oe;
    logic        _req_bhe;
    logic        _req_ble;
    logic [22:1] req_address;
    logic [15:0] req_data;
    logic [15:0] rddata;
    logic        ack;
    logic        busy;
    logic        _sram_ce;
    logic        _sram_oe;
    logic        _sram_we;
    logic        _sram_bhe;
    logic        _sram_ble;
    logic [22:1] sram_address;
    logic [15:0] sram_dout;
    logic        sram_doe;
    logic [15:0] sram_din;

    modport slave (
        input  _req_we, _req_oe, _req_bhe, _req_ble, req_address, req_data, sram_din,
        output rddata, ack, busy, _sram_ce, _sram_oe, _sram_we, _sram_bhe, _sram_ble,
               sram_address, sram_dout, sram_doe
    );

    modport master (
        output _req_we, _req_oe, _req_bhe, _req_ble, req_address, req_data, sram_din,
        input  rddata, ack, busy, _sram_ce, _sram_oe, _sram_we, _sram_bhe, _sram_ble,
               sram_address, sram_dout, sram_doe
    );
endinterface

// File: rtl/minimig_sram_sequencer.sv
// Sequences one asynchronous SRAM access per bridge request: SETUP, STROBE (WAIT_STATES+1),
// HOLD with ack, then WAITREL until the bridge drops its request. All outputs are registered.
module minimig_sram_sequencer #(
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                       clk,
    input  logic                       _reset,
    minimig_sram_sequencer_if.slave    bus
);

    typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StWaitrel} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic        lane_bhe_q, lane_bhe_d;
    logic        lane_ble_q, lane_ble_d;
    logic [22:1] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [15:0] rddata_q, rddata_d;
    logic        ce_q, oe_q, we_q, bhe_q, ble_q, doe_q, ack_q, busy_q;
    logic        ce_d, oe_d, we_d, bhe_d, ble_d, doe_d, ack_d, busy_d;
    logic        setup_n, strobe_n, hold_n;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        lane_bhe_d = lane_bhe_q;
        lane_ble_d = lane_ble_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rddata_d   = rddata_q;
        unique case (state_q)
            StIdle: begin
                if (!bus._req_we || !bus._req_oe) begin
                    write_d    = ~bus._req_we;
                    lane_bhe_d = bus._req_bhe;
                    lane_ble_d = bus._req_ble;
                    addr_d     = bus.req_address;
                    data_d     = bus.req_data;
                    cnt_d      = 4'(WAIT_STATES);
                    state_d    = StSetup;
                end
            end
            StSetup: state_d = StStrobe;
            StStrobe: begin
                if (cnt_q == 4'd0) begin
                    state_d = StHold;
                    if (!write_q) rddata_d = bus.sram_din;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StHold: state_d = StWaitrel;
            StWaitrel: begin
                // Hold off until the bridge lets go so a held request is serviced once.
                if (bus._req_we && bus._req_oe) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Strobes are computed from the next state so they appear registered in the state they
    // belong to; the read/write and lane decisions come from the latched request only.
    always_comb begin
        setup_n  = (state_d == StSetup);
        strobe_n = (state_d == StStrobe);
        hold_n   = (state_d == StHold);
        ce_d     = ~(setup_n | strobe_n | hold_n);
        oe_d     = ~(~write_d & (setup_n | strobe_n));
        we_d     = ~(write_d & strobe_n & ~(lane_bhe_d & lane_ble_d));
        bhe_d    = ~(strobe_n & (~write_d | ~lane_bhe_d));
        ble_d    = ~(strobe_n & (~write_d | ~lane_ble_d));
        doe_d    = write_d & (setup_n | strobe_n | hold_n);
        ack_d    = hold_n;
        busy_d   = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            write_q    <= 1'b0;
            lane_bhe_q <= 1'b1;
            lane_ble_q <= 1'b1;
            addr_q     <= '0;
            data_q     <= '0;
            rddata_q   <= '0;
            ce_q       <= 1'b1;
            oe_q       <= 1'b1;
            we_q       <= 1'b1;
            bhe_q      <= 1'b1;
            ble_q      <= 1'b1;
            doe_q      <= 1'b0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            write_q    <= write_d;
            lane_bhe_q <= lane_bhe_d;
            lane_ble_q <= lane_ble_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rddata_q   <= rddata_d;
            ce_q       <= ce_d;
            oe_q       <= oe_d;
            we_q       <= we_d;
            bhe_q      <= bhe_d;
            ble_q      <= ble_d;
            doe_q      <= doe_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.rddata       = rddata_q;
    assign bus.ack          = ack_q;
    assign bus.busy         = busy_q;
    assign bus._sram_ce     = ce_q;
    assign bus._sram_oe     = oe_q;
    assign bus._sram_we     = we_q;
    assign bus._sram_bhe    = bhe_q;
    assign bus._sram_ble    = ble_q;
    assign bus.sram_address = addr_q;
    assign bus.sram_dout    = data_q;
    assign bus.sram_doe     = doe_q;

endmodule

// File: tb/tb_minimig_sram_sequencer.sv
// Drives three sequencers (WAIT_STATES 2, 0, 15) with identical requests and checks each
// cycle against a timeline model, plus literal timing/data expectations per access.
module tb_minimig_sram_sequencer;

    typedef struct packed {
        logic [15:0] rddata;
        logic        ack;
        logic        busy;
        logic        ce;
        logic        oe;
        logic        we;
        logic        bhe;
        logic        ble;
        logic        doe;
        logic [21:0] addr;
        logic [15:0] dout;
    } obs_t;

    function automatic int ws_of(int i);
        case (i)
            0:       return 2;
            1:       return 0;
            default: return 15;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_we, req_oe, req_bhe, req_ble;
    logic [21:0] req_address;
    logic [15:0] req_data;
    logic [15:0] sram_din;
    obs_t        obs [3];
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        minimig_sram_sequencer_if bus ();
        assign bus._req_we     = req_we;
        assign bus._req_oe     = req_oe;
        assign bus._req_bhe    = req_bhe;
        assign bus._req_ble    = req_ble;
        assign bus.req_address = req_address;
        assign bus.req_data    = req_data;
        assign bus.sram_din    = sram_din;
        assign obs[g] = {bus.rddata, bus.ack, bus.busy, bus._sram_ce, bus._sram_oe,
                         bus._sram_we, bus._sram_bhe, bus._sram_ble, bus.sram_doe,
                         bus.sram_address, bus.sram_dout};
        minimig_sram_sequencer #(.WAIT_STATES(ws_of(g))) u_dut (
            .clk    (clk),
            ._reset (reset_n),
            .bus    (bus)
        );
    end

    // Model: m_rel counts clocks since the sampling edge (0 = idle); the clk-n layout is
    // 1 setup, 2..W+2 strobe, W+3 hold, W+4 waiting for release.
    int          m_rel  [3];
    logic        m_wr   [3];
    logic        m_bhe  [3];
    logic        m_ble  [3];
    logic [21:0] m_addr [3];
    logic [15:0] m_data [3];
    logic [15:0] m_rd   [3];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                m_rel[i]  <= 0;
                m_wr[i]   <= 1'b0;
                m_bhe[i]  <= 1'b1;
                m_ble[i]  <= 1'b1;
                m_addr[i] <= '0;
                m_data[i] <= '0;
                m_rd[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                int w;
                w = ws_of(i);
                if (m_rel[i] == 0) begin
                    if (!req_we || !req_oe) begin
                        m_rel[i]  <= 1;
                        m_wr[i]   <= !req_we;
                        m_bhe[i]  <= req_bhe;
                        m_ble[i]  <= req_ble;
                        m_addr[i] <= req_address;
                        m_data[i] <= req_data;
                    end
                end else if (m_rel[i] == w + 3) begin
                    m_rel[i] <= w + 4;
                end else if (m_rel[i] > w + 3) begin
                    if (req_we && req_oe) m_rel[i] <= 0;
                end else begin
                    m_rel[i] <= m_rel[i] + 1;
                    if (m_rel[i] == w + 2 && !m_wr[i]) m_rd[i] <= sram_din;
                end
            end
        end
    end

    function automatic obs_t expect_of(int i);
        obs_t e;
        int   w, r;
        logic in_setup, in_strobe, in_hold, no_lanes;
        w         = ws_of(i);
        r         = m_rel[i];
        in_setup  = (r == 1);
        in_strobe = (r >= 2) && (r <= w + 2);
        in_hold   = (r == w + 3);
        no_lanes  = m_bhe[i] && m_ble[i];
        e.rddata  = m_rd[i];
        e.ack     = in_hold;
        e.busy    = (r != 0);
        e.ce      = !(r >= 1 && r <= w + 3);
        e.oe      = !(!m_wr[i] && r >= 1 && r <= w + 2);
        e.we      = !(m_wr[i] && in_strobe && !no_lanes);
        e.bhe     = !(in_strobe && (!m_wr[i] || !m_bhe[i]));
        e.ble     = !(in_strobe && (!m_wr[i] || !m_ble[i]));
        e.doe     = m_wr[i] && (in_setup || in_strobe || in_hold);
        e.addr    = m_addr[i];
        e.dout    = m_data[i];
        return e;
    endfunction

    int checks = 0;
    int failures = 0;
    int start_cyc = 0;
    int ack_cnt [3];
    int ack_clk [3];
    int we_cnt  [3];
    int oe_cnt  [3];

    const int ACK_CLK_LIT [3] = '{5, 3, 18};
    const int WE_LOW_LIT  [3] = '{3, 1, 16};
    const int OE_LOW_LIT  [3] = '{4, 2, 17};

    task automatic check(input string name, input int inst, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d got=%0h expected=%0h", name, inst, got, exp);
        end
    endtask

    task automatic clear_mon();
        start_cyc = cyc;
        for (int i = 0; i < 3; i++) begin
            ack_cnt[i] = 0;
            ack_clk[i] = -1;
            we_cnt[i]  = 0;
            oe_cnt[i]  = 0;
        end
    endtask

    // One clock: compare every instance against the model and tally strobe activity.
    task automatic tick();
        obs_t e;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            e = expect_of(i);
            check("model_cmp", i, 64'(obs[i]), 64'(e));
            if (obs[i].ack) begin
                ack_cnt[i]++;
                ack_clk[i] = cyc - start_cyc;
            end
            if (!obs[i].we) we_cnt[i]++;
            if (!obs[i].oe) oe_cnt[i]++;
        end
    endtask

    task automatic run_access(input logic we_n, input logic oe_n, input logic bhe_n,
                              input logic ble_n, input logic [21:0] addr,
                              input logic [15:0] data, input logic [15:0] din);
        clear_mon();
        req_we = we_n; req_oe = oe_n; req_bhe = bhe_n; req_ble = ble_n;
        req_address = addr; req_data = data; sram_din = din;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 2) begin
                req_address = ~addr; req_data = ~data; req_bhe = ~bhe_n; req_ble = ~ble_n;
            end
        end
        req_we = 1'b1; req_oe = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) check("idle_after_release", i, 64'(obs[i].busy), 64'd0);
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            check("ack_count", i, 64'(ack_cnt[i]), 64'd1);
            check("ack_clk", i, 64'(ack_clk[i]), 64'(ACK_CLK_LIT[i]));
            check("addr_latched", i, 64'(obs[i].addr), 64'(addr));
            check("dout_latched", i, 64'(obs[i].dout), 64'(data));
        end
    endtask

    initial begin
        reset_n = 1'b0;
        req_we = 1'b1; req_oe = 1'b1; req_bhe = 1'b1; req_ble = 1'b1;
        req_address = '0; req_data = '0; sram_din = 16'h0000;
        clear_mon();
        repeat (2) tick();
        for (int i = 0; i < 3; i++)
            check("reset_state", i, 64'(obs[i]), 64'({16'h0, 8'b0011_1110, 22'h0, 16'h0}));
        reset_n = 1'b1;
        repeat (2) tick();

        // Read with held request; lanes ignored for reads.
        run_access(1'b1, 1'b0, 1'b1, 1'b0, 22'h012345, 16'h1111, 16'hBEEF);
        for (int i = 0; i < 3; i++) begin
            check("read_rddata", i, 64'(obs[i].rddata), 64'h0000_BEEF);
            check("read_oe_low_clks", i, 64'(oe_cnt[i]), 64'(OE_LOW_LIT[i]));
            check("read_we_low_clks", i, 64'(we_cnt[i]), 64'd0);
        end

        // Upper-byte write; rddata must keep the previous read.
        run_access(1'b0, 1'b1, 1'b0, 1'b1, 22'h02AAAA, 16'hA55A, 16'h1234);
        for (int i = 0; i < 3; i++) begin
            check("write_we_low_clks", i, 64'(we_cnt[i]), 64'(WE_LOW_LIT[i]));
            check("write_oe_low_clks", i, 64'(oe_cnt[i]), 64'd0);
            check("rddata_hold", i, 64'(obs[i].rddata), 64'h0000_BEEF);
        end

        // Both requests low -> write wins.
        run_access(1'b0, 1'b0, 1'b0, 1'b0, 22'h3FFFFF, 16'h0F0F, 16'h7777);
        for (int i = 0; i < 3; i++) begin
            check("both_low_oe_clks", i, 64'(oe_cnt[i]), 64'd0);
            check("both_low_we_clks", i, 64'(we_cnt[i]), 64'(WE_LOW_LIT[i]));
        end

        // Write with no lanes: full sequence, no write strobe.
        run_access(1'b0, 1'b1, 1'b1, 1'b1, 22'h000100, 16'hFFFF, 16'h0000);
        for (int i = 0; i < 3; i++) check("no_lane_we_clks", i, 64'(we_cnt[i]), 64'd0);

        run_access(1'b1, 1'b0, 1'b0, 1'b0, 22'h000000, 16'h0000, 16'h5AA5);
        for (int i = 0; i < 3; i++) check("read2_rddata", i, 64'(obs[i].rddata), 64'h5AA5);

        // Reset pulsed during the write strobe of every instance.
        clear_mon();
        req_we = 1'b0; req_oe = 1'b1; req_bhe = 1'b0; req_ble = 1'b0;
        req_address = 22'h00F00D; req_data = 16'hCAFE;
        repeat (2) tick();
        check("pre_reset_we_low", 0, 64'(obs[0].we), 64'd0);
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++)
            check("reset_abort", i, 64'({obs[i].ce, obs[i].we, obs[i].doe, obs[i].ack,
                                         obs[i].busy}), 64'b11000);
        req_we = 1'b1;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            check("reset_no_ack", i, 64'(ack_cnt[i]), 64'd0);
            check("reset_idle", i, 64'(obs[i].busy), 64'd0);
        end

        run_access(1'b1, 1'b0, 1'b1, 1'b1, 22'h000ABC, 16'h2222, 16'hC3C3);
        for (int i = 0; i < 3; i++) check("post_reset_rddata", i, 64'(obs[i].rddata), 64'hC3C3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
